rst_seq: RTL and testbench
==========================

// Module: rst_seq
// PURPOSE
//  Parametrised reset sequencer; successor to the single-output PLL-lock reset stretcher.
//  Filters the PLL lock signal, holds all resets for a programmable time, then releases
//  N_OUT reset domains in staged order (index 0 first).
//  Re-asserts all domains on lock loss, or on a software reset request handshake.
//  Sits after the PLL; rst_out bits feed SB_GB buffers or local reset trees.
// PARAMETERS
//  N_OUT      3   number of reset domains (1..16)
//  LOCK_FILT  16  consecutive cycles pll_lock must be high before sequencing (>=1)
//  HOLD_CYC   8   cycles all resets stay asserted after the lock filter passes (>=1)
//  STAGE_GAP  4   cycles between successive domain releases (>=1)
//  CNT_W      8   width of the shared timer; must hold max(LOCK_FILT,HOLD_CYC,STAGE_GAP)
// PORTS
//  clk         in   1      system clock (PLL output)
//  rst         in   1      synchronous, active-high reset
//  pll_lock    in   1      raw PLL lock; treated as synchronous to clk
//  sw_rst_req  in   1      level request to reset all domains
//  sw_rst_ack  out  1      high while all domains are held for a software request
//  rst_out     out  N_OUT  per-domain reset, active-high, registered
//  ready       out  1      all domains released (state RUN)
//  lost_cnt    out  8      lock-loss events, saturating at 255
// BEHAVIOUR
//  - All outputs registered. While rst=1: state WAIT_LOCK, rst_out all ones, ready=0,
//    sw_rst_ack=0, lost_cnt=0, timer=0, stage=0.
//  - WAIT_LOCK: timer counts cycles with pll_lock=1; pll_lock=0 clears timer.
//    After LOCK_FILT consecutive high samples -> HOLD, timer cleared.
//  - HOLD: after HOLD_CYC cycles -> RELEASE; rst_out[0] cleared on that same edge, stage=1.
//  - RELEASE: every STAGE_GAP cycles clear rst_out[stage], stage++.
//    On clearing rst_out[N_OUT-1] -> RUN, with ready=1 on the same edge.
//    If N_OUT=1, HOLD goes directly to RUN.
//  - Timing from the first high lock sample at cycle 0 (defaults):
//    rst_out[k] low from cycle LOCK_FILT+HOLD_CYC+k*STAGE_GAP, i.e. 24/28/32.
//  - RUN: rst_out all zero, ready=1.
//  - Lock loss: pll_lock=0 in HOLD, RELEASE, RUN or SW_HOLD -> next edge rst_out all ones,
//    ready=0, sw_rst_ack=0, state WAIT_LOCK, lost_cnt+1 (saturating).
//    In WAIT_LOCK a lock drop only clears the timer; it does not count.
//  - Software reset: sw_rst_req=1 in RUN or RELEASE -> next edge rst_out all ones, ready=0,
//    state SW_HOLD, sw_rst_ack=1. Ack stays high while req stays high.
//    When req drops: ack=0, timer cleared, state HOLD; the full HOLD+RELEASE sequence replays.
//  - sw_rst_req in WAIT_LOCK/HOLD is ignored; resets are already asserted and no ack is given.
//  - Priority on simultaneous events: rst > lock loss > sw_rst_req > timer expiry.
//  - Timer is CNT_W bits and never wraps; it is cleared on every state change.
//  - Stage index is $clog2(N_OUT+1) bits.
//  - A release bit, once cleared, stays cleared until the next all-assert event.
//    Domains never release out of order.
// STRUCTURE
//  - Shared package rst_seq_pkg: state encoding localparams
//    (WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3, SW_HOLD=4), 3-bit state width,
//    and LOST_W=8.
//  - One sub-module, rst_seq_timer: CNT_W-bit up-counter with clear input and
//    terminal-compare output (cnt == limit-1). It is shared by all states, with the
//    limit muxed by state.
//  - Top level: FSM, stage counter, rst_out shift-clear register, lost_cnt saturator.
// TESTING  (defaults unless stated)
//  - Power-up: rst high 5 cycles, then pll_lock=1 constant.
//    -> rst_out=3'b111 until cycle 24; 3'b110 at 24; 3'b100 at 28; 3'b000 and ready=1 at 32.
//  - Glitchy lock: lock high 10, low 1, high constant.
//    -> sequencing restarts from the re-rise; lost_cnt stays 0; rst_out[0] falls 24 cycles after the re-rise.
//  - Lock loss in RUN: drop pll_lock 1 cycle.
//    -> next edge rst_out=3'b111, ready=0, lost_cnt=1; full sequence replays after the lock returns.
//  - SW reset: in RUN assert sw_rst_req for 6 cycles.
//    -> ack high cycles 1..6 after assert; on release rst_out[0] falls HOLD_CYC=8 cycles after ack drops, then 4-cycle gaps.
//  - Collision: sw_rst_req and pll_lock=0 on the same cycle in RUN.
//    -> WAIT_LOCK, ack stays 0, lost_cnt increments.
//  - Saturation and mid-sequence reset: 300 lock drops -> lost_cnt=255.
//    Then rst pulse during RELEASE -> all outputs at reset values on the next edge.
//  - N_OUT=1 variant: a single release at cycle 24 with ready on the same edge.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, widths and a saturating
// increment helper.
package rst_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LOST_W  = 8;

  localparam logic [STATE_W-1:0] WAIT_LOCK = 3'd0;
  localparam logic [STATE_W-1:0] HOLD      = 3'd1;
  localparam logic [STATE_W-1:0] RELEASE   = 3'd2;
  localparam logic [STATE_W-1:0] RUN       = 3'd3;
  localparam logic [STATE_W-1:0] SW_HOLD   = 3'd4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
    return (v == '1) ? v : v + LOST_W'(1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Shared interval timer: counts enabled cycles from zero and flags the cycle on which
// the count reaches limit-1. Holds at all-ones rather than wrapping.
module rst_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: clear wins over enable; saturate at the top value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: filters PLL lock, holds every domain in reset for a fixed time, then
// releases the domains one by one (index 0 first). Lock loss or a software request
// re-asserts all domains.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_OUT     = 3,
  parameter int unsigned LOCK_FILT = 16,
  parameter int unsigned HOLD_CYC  = 8,
  parameter int unsigned STAGE_GAP = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              sw_rst_req,
  output logic              sw_rst_ack,
  output logic [N_OUT-1:0]  rst_out,
  output logic              ready,
  output logic [LOST_W-1:0] lost_cnt
);

  localparam int unsigned STAGE_W = $clog2(N_OUT + 1);

  logic [STATE_W-1:0] state_d, state_q;
  logic [STAGE_W-1:0] stage_d, stage_q;
  logic [N_OUT-1:0]   rst_out_d, rst_out_q;
  logic               ready_d, ready_q;
  logic               ack_d, ack_q;
  logic [LOST_W-1:0]  lost_d, lost_q;

  logic               tmr_en, tmr_clr, tmr_clr_evt, tmr_done;
  logic [CNT_W-1:0]   tmr_limit;

  // Interval length for whichever state is currently timing.
  always_comb begin
    case (state_q)
      WAIT_LOCK: tmr_limit = CNT_W'(LOCK_FILT);
      HOLD:      tmr_limit = CNT_W'(HOLD_CYC);
      default:   tmr_limit = CNT_W'(STAGE_GAP);
    endcase
  end

  rst_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .done_o  (tmr_done)
  );

  // Timer restarts on every state change as well as on explicit in-state events.
  assign tmr_clr = tmr_clr_evt || (state_d != state_q);

  // Sequencing FSM; lock loss outranks the software request, which outranks expiry.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    ack_d       = ack_q;
    lost_d      = lost_q;
    tmr_en      = 1'b0;
    tmr_clr_evt = 1'b0;

    if ((state_q != WAIT_LOCK) && !pll_lock) begin
      state_d   = WAIT_LOCK;
      stage_d   = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      ack_d     = 1'b0;
      lost_d    = sat_inc(lost_q);
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!pll_lock) begin
            tmr_clr_evt = 1'b1;
          end else if (tmr_done) begin
            state_d = HOLD;
          end else begin
            tmr_en = 1'b1;
          end
        end
        HOLD: begin
          if (tmr_done) begin
            rst_out_d[0] = 1'b0;
            stage_d      = STAGE_W'(1);
            if (N_OUT == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        RELEASE: begin
          if (sw_rst_req) begin
            state_d   = SW_HOLD;
            stage_d   = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            ack_d     = 1'b1;
          end else if (tmr_done) begin
            // Clearing every index up to the stage keeps releases strictly in order.
            for (int unsigned i = 0; i < N_OUT; i++) begin
              if (STAGE_W'(i) <= stage_q) begin
                rst_out_d[i] = 1'b0;
              end
            end
            stage_d = stage_q + STAGE_W'(1);
            if (stage_q == STAGE_W'(N_OUT - 1)) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              tmr_clr_evt = 1'b1;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        RUN: begin
          if (sw_rst_req) begin
            state_d   = SW_HOLD;
            stage_d   = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            ack_d     = 1'b1;
          end
        end
        SW_HOLD: begin
          if (!sw_rst_req) begin
            state_d = HOLD;
            ack_d   = 1'b0;
          end
        end
        default: begin
          state_d   = WAIT_LOCK;
          stage_d   = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
          ack_d     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      stage_q   <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      lost_q    <= lost_d;
    end
  end

  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign sw_rst_ack = ack_q;
  assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: drives a 3-domain and a 1-domain instance from the same inputs and
// checks both against a time-based reference model through a scoreboard queue.
module tb_rst_seq;

  localparam int LockFilt = 16;
  localparam int HoldCyc  = 8;
  localparam int StageGap = 4;

  logic clk = 1'b0;
  logic rst, pll_lock, sw_rst_req;

  logic       ack3, ready3, ack1, ready1;
  logic [2:0] rst_out3;
  logic [0:0] rst_out1;
  logic [7:0] lost3, lost1;

  always #5 clk = ~clk;

  rst_seq #(
    .N_OUT     (3),
    .LOCK_FILT (LockFilt),
    .HOLD_CYC  (HoldCyc),
    .STAGE_GAP (StageGap),
    .CNT_W     (8)
  ) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (ack3),
    .rst_out    (rst_out3),
    .ready      (ready3),
    .lost_cnt   (lost3)
  );

  rst_seq #(
    .N_OUT     (1),
    .LOCK_FILT (LockFilt),
    .HOLD_CYC  (HoldCyc),
    .STAGE_GAP (StageGap),
    .CNT_W     (8)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (ack1),
    .rst_out    (rst_out1),
    .ready      (ready1),
    .lost_cnt   (lost1)
  );

  typedef struct {
    int         n;
    logic [2:0] r3;
    logic       rdy3;
    logic       r1;
    logic       rdy1;
    logic       ack;
    logic [7:0] lost;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: domain k is released once the edge count reaches the domain-0
  // release time plus k gaps; everything else is mode bookkeeping.
  typedef enum int {MWait, MSeq, MSw} mmode_t;
  mmode_t m_mode = MWait;
  int     m_n = 0, m_hi_run = 0, m_t_rel = 0, m_lost = 0;
  logic   m_ack = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      m_n++;
      if (rst) begin
        m_mode = MWait; m_hi_run = 0; m_lost = 0; m_ack = 1'b0;
      end else if (m_mode == MWait) begin
        if (pll_lock) begin
          m_hi_run++;
          if (m_hi_run == LockFilt) begin
            m_mode  = MSeq;
            m_t_rel = m_n + HoldCyc;
          end
        end else begin
          m_hi_run = 0;
        end
      end else if (!pll_lock) begin
        m_mode = MWait; m_hi_run = 0; m_ack = 1'b0;
        if (m_lost < 255) m_lost++;
      end else if (m_mode == MSw) begin
        if (!sw_rst_req) begin
          m_mode  = MSeq;
          m_ack   = 1'b0;
          m_t_rel = m_n + HoldCyc;
        end
      end else if (sw_rst_req && (m_n > m_t_rel)) begin
        m_mode = MSw;
        m_ack  = 1'b1;
      end
      e.n = m_n;
      for (int k = 0; k < 3; k++) begin
        e.r3[k] = !((m_mode == MSeq) && (m_n >= m_t_rel + k * StageGap));
      end
      e.rdy3 = !e.r3[2];
      e.r1   = !((m_mode == MSeq) && (m_n >= m_t_rel));
      e.rdy1 = !e.r1;
      e.ack  = m_ack;
      e.lost = 8'(m_lost);
      sb_q.push_back(e);
    end
  end

  // Monitor: outputs are registered, so compare once per cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if ({rst_out3, ready3, ack3, lost3} !== {e.r3, e.rdy3, e.ack, e.lost}) begin
          miscompares++;
          $display("FAIL dut3 edge=%0d got rst_out=%b ready=%b ack=%b lost=%0d want rst_out=%b ready=%b ack=%b lost=%0d",
                   e.n, rst_out3, ready3, ack3, lost3, e.r3, e.rdy3, e.ack, e.lost);
        end
        vectors++;
        if ({rst_out1, ready1, ack1, lost1} !== {e.r1, e.rdy1, e.ack, e.lost}) begin
          miscompares++;
          $display("FAIL dut1 edge=%0d got rst_out=%b ready=%b ack=%b lost=%0d want rst_out=%b ready=%b ack=%b lost=%0d",
                   e.n, rst_out1, ready1, ack1, lost1, e.r1, e.rdy1, e.ack, e.lost);
        end
      end
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0; sw_rst_req = 1'b0;
    idle(5);
    // Power-up sequence.
    rst = 1'b0; pll_lock = 1'b1; idle(40);
    // One-cycle lock loss in RUN.
    pll_lock = 1'b0; idle(1); pll_lock = 1'b1; idle(40);
    // Software reset held for six cycles.
    sw_rst_req = 1'b1; idle(6); sw_rst_req = 1'b0; idle(40);
    // Software request colliding with lock loss.
    sw_rst_req = 1'b1; pll_lock = 1'b0; idle(1);
    sw_rst_req = 1'b0; pll_lock = 1'b1; idle(40);
    // Glitchy lock straight out of reset.
    rst = 1'b1; pll_lock = 1'b0; idle(3);
    rst = 1'b0; pll_lock = 1'b1; idle(10);
    pll_lock = 1'b0; idle(1); pll_lock = 1'b1; idle(40);
    // Randomized lock drops and software requests.
    for (int i = 0; i < 2000; i++) begin
      pll_lock = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 19) == 0) sw_rst_req = ~sw_rst_req;
      idle(1);
    end
    sw_rst_req = 1'b0; pll_lock = 1'b1; idle(40);
    // Drive the loss counter into saturation from HOLD.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1; idle(LockFilt + 1);
      pll_lock = 1'b0; idle(1);
    end
    // Reset pulse in the middle of RELEASE.
    pll_lock = 1'b1; idle(LockFilt + HoldCyc + 2);
    rst = 1'b1; idle(1);
    rst = 1'b0; idle(40);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
